// File: rtl/pmem_write_buffer.sv
// Write-back line buffer between the cache-side memory port and physical memory.
// Define PMEM_WB_FORWARD_EN to answer read hits directly from the buffer.
module pmem_write_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [31:0]  mem_address,
   input  logic [255:0] mem_wdata,
   output logic         mem_resp,
   output logic [255:0] mem_rdata,
   output logic         mem_error,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_address,
   output logic [255:0] pmem_wdata,
   input  logic [255:0] pmem_rdata,
   input  logic         pmem_resp,
   input  logic         pmem_error
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] Full = CntW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StFill, StDrain, StResp} state_e;

   state_e state_q, state_d;

   logic [DEPTH-1:0] valid_q;
   logic [26:0]      tag_q  [DEPTH];
   logic [255:0]     data_q [DEPTH];
   logic [PtrW-1:0]  head_q, tail_q;
   logic [CntW-1:0]  count_q;

   logic         mem_resp_q, mem_resp_d;
   logic [255:0] mem_rdata_q, mem_rdata_d;
   logic         mem_error_q, mem_error_d;
   logic         pmem_read_q, pmem_read_d;
   logic         pmem_write_q, pmem_write_d;
   logic [31:0]  pmem_address_q, pmem_address_d;
   logic [255:0] pmem_wdata_q, pmem_wdata_d;

   logic [26:0]     req_tag;
   logic            hit;
   logic [PtrW-1:0] hit_idx;
   logic            enq, coal, deq, start_drain;
   logic            unused_addr;

   assign req_tag     = mem_address[31:5];
   assign unused_addr = ^mem_address[4:0];

   // Tags are unique within the buffer, so at most one entry can match.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (tag_q[i] == req_tag)) begin
            hit     = 1'b1;
            hit_idx = PtrW'(i);
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      mem_resp_d     = 1'b0;
      mem_rdata_d    = mem_rdata_q;
      mem_error_d    = mem_error_q;
      pmem_read_d    = pmem_read_q;
      pmem_write_d   = pmem_write_q;
      pmem_address_d = pmem_address_q;
      pmem_wdata_d   = pmem_wdata_q;
      enq            = 1'b0;
      coal           = 1'b0;
      deq            = 1'b0;
      start_drain    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (mem_read) begin
               if (!hit) begin
                  state_d        = StFill;
                  pmem_read_d    = 1'b1;
                  pmem_address_d = {req_tag, 5'b0};
               end else begin
`ifdef PMEM_WB_FORWARD_EN
                  state_d     = StResp;
                  mem_resp_d  = 1'b1;
                  mem_rdata_d = data_q[hit_idx];
                  mem_error_d = 1'b0;
`else
                  // Push the matching line out to memory first, then re-evaluate.
                  start_drain = 1'b1;
`endif
               end
            end else if (mem_write && (hit || (count_q != Full))) begin
               coal        = hit;
               enq         = !hit;
               state_d     = StResp;
               mem_resp_d  = 1'b1;
               mem_error_d = 1'b0;
            end else if (count_q != '0) begin
               // Also covers a write miss against a full buffer.
               start_drain = 1'b1;
            end

            if (start_drain) begin
               state_d        = StDrain;
               pmem_write_d   = 1'b1;
               pmem_address_d = {tag_q[head_q], 5'b0};
               pmem_wdata_d   = data_q[head_q];
            end
         end

         StFill: begin
            if (pmem_resp) begin
               state_d     = StResp;
               pmem_read_d = 1'b0;
               mem_resp_d  = 1'b1;
               mem_rdata_d = pmem_rdata;
               mem_error_d = pmem_error;
            end
         end

         StDrain: begin
            // Drain errors are ignored; the line is dropped either way.
            if (pmem_resp) begin
               state_d      = StIdle;
               pmem_write_d = 1'b0;
               deq          = 1'b1;
            end
         end

         StResp: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         valid_q        <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         mem_resp_q     <= 1'b0;
         mem_rdata_q    <= '0;
         mem_error_q    <= 1'b0;
         pmem_read_q    <= 1'b0;
         pmem_write_q   <= 1'b0;
         pmem_address_q <= '0;
         pmem_wdata_q   <= '0;
      end else begin
         state_q        <= state_d;
         mem_resp_q     <= mem_resp_d;
         mem_rdata_q    <= mem_rdata_d;
         mem_error_q    <= mem_error_d;
         pmem_read_q    <= pmem_read_d;
         pmem_write_q   <= pmem_write_d;
         pmem_address_q <= pmem_address_d;
         pmem_wdata_q   <= pmem_wdata_d;

         if (enq) begin
            valid_q[tail_q] <= 1'b1;
            tag_q[tail_q]   <= req_tag;
            data_q[tail_q]  <= mem_wdata;
            tail_q          <= tail_q + 1'b1;
         end
         if (coal) begin
            data_q[hit_idx] <= mem_wdata;
         end
         if (deq) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + 1'b1;
         end
         count_q <= count_q + CntW'(enq) - CntW'(deq);
      end
   end

   assign mem_resp     = mem_resp_q;
   assign mem_rdata    = mem_rdata_q;
   assign mem_error    = mem_error_q;
   assign pmem_read    = pmem_read_q;
   assign pmem_write   = pmem_write_q;
   assign pmem_address = pmem_address_q;
   assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_pmem_write_buffer.sv
// Bench for pmem_write_buffer: directed scenarios plus random traffic checked against
// a line-level model (ordered list of buffered lines, newest value per line, memory image).
module tb_pmem_write_buffer;

   localparam int unsigned DEPTH = 4;

   logic         clk, rst;
   logic         mem_read, mem_write;
   logic [31:0]  mem_address;
   logic [255:0] mem_wdata;
   logic         mem_resp;
   logic [255:0] mem_rdata;
   logic         mem_error;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata, pmem_rdata;
   logic         pmem_resp, pmem_error;

   pmem_write_buffer #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_wdata    (mem_wdata),
      .mem_resp     (mem_resp),
      .mem_rdata    (mem_rdata),
      .mem_error    (mem_error),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .pmem_error   (pmem_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [26:0]  tag;
      logic [255:0] data;
   } line_t;

   int n_cmp = 0;
   int n_err = 0;

   line_t        buf_q[$];                  // lines the buffer should hold, oldest first
   logic [255:0] shadow [logic [26:0]];     // newest value written per line
   logic [255:0] phys   [logic [26:0]];     // physical memory image

   bit   hold_resp   = 1'b0;
   bit   force_err   = 1'b0;
   int   drain_cnt   = 0;
   int   rd_cnt      = 0;
   logic last_rd_err = 1'b0;

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] init_line(input logic [26:0] t);
      logic [31:0] w;
      w = {t, 5'b0} ^ 32'hC0DE_0000;
      return {8{w}};
   endfunction

   function automatic logic [255:0] shadow_val(input logic [26:0] t);
      return shadow.exists(t) ? shadow[t] : init_line(t);
   endfunction

   function automatic logic [255:0] phys_val(input logic [26:0] t);
      return phys.exists(t) ? phys[t] : init_line(t);
   endfunction

   function automatic bit in_buf(input logic [26:0] t);
      foreach (buf_q[i]) if (buf_q[i].tag == t) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [255:0] rand_line();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Physical memory: random latency, optional hold-off, checks drain order and stability.
   initial begin : responder
      int           lat;
      bit           busy;
      bit           is_wr;
      logic [31:0]  a0;
      logic [255:0] d0;
      line_t        e;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      pmem_error = 1'b0;
      busy = 1'b0;
      lat  = 0;
      forever begin
         @(posedge clk); #1;
         pmem_resp = 1'b0;
         if (rst) begin
            busy = 1'b0;
            continue;
         end
         if (busy) check_eq("pmem_held", pmem_read | pmem_write, 1'b1);
         if (pmem_read || pmem_write) begin
            check_eq("pmem_exclusive", pmem_read & pmem_write, 1'b0);
            if (!busy) begin
               busy  = 1'b1;
               is_wr = pmem_write;
               a0    = pmem_address;
               d0    = pmem_wdata;
               lat   = $urandom_range(0, 3);
               if (pmem_read) begin
                  check_eq("rd_addr_low", a0[4:0], 5'd0);
                  check_eq("rd_line_not_buffered", in_buf(a0[31:5]), 1'b0);
               end
            end else begin
               check_eq("pmem_addr_stable", pmem_address, a0);
               if (is_wr) check_eq("pmem_wdata_stable", pmem_wdata, d0);
            end
            if (!hold_resp) begin
               if (lat == 0) begin
                  pmem_resp = 1'b1;
                  busy      = 1'b0;
                  if (is_wr) begin
                     pmem_error = ($urandom_range(0, 3) == 0);
                     drain_cnt++;
                     check_eq("drain_expected", buf_q.size() != 0, 1'b1);
                     if (buf_q.size() != 0) begin
                        e = buf_q.pop_front();
                        check_eq("drain_addr", a0, {e.tag, 5'b0});
                        check_eq("drain_data", d0, e.data);
                     end
                     phys[a0[31:5]] = d0;
                  end else begin
                     pmem_rdata  = phys_val(a0[31:5]);
                     pmem_error  = force_err | ($urandom_range(0, 3) == 0);
                     last_rd_err = pmem_error;
                     rd_cnt++;
                  end
               end else begin
                  lat--;
               end
            end
         end
      end
   end

   initial begin : pulse_mon
      logic prev;
      prev = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (prev) check_eq("resp_one_cycle", mem_resp, 1'b0);
         prev = mem_resp;
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_write(input logic [31:0] addr, input logic [255:0] data, output int lat);
      logic [26:0] t;
      bit          done;
      int          idx;
      line_t       e;
      t           = addr[31:5];
      mem_write   = 1'b1;
      mem_address = addr;
      mem_wdata   = data;
      lat  = 0;
      done = 1'b0;
      while (!done && lat < 300) begin
         @(posedge clk); #1;
         lat++;
         if (mem_resp) done = 1'b1;
      end
      mem_write = 1'b0;
      check_eq("write_done", done, 1'b1);
      if (!done) return;
      idx = -1;
      foreach (buf_q[i]) if (buf_q[i].tag == t) idx = i;
      if (idx >= 0) begin
         e = buf_q[idx];
         e.data = data;
         buf_q[idx] = e;
      end else begin
         check_eq("write_not_overflow", buf_q.size() < DEPTH, 1'b1);
         buf_q.push_back({t, data});
      end
      shadow[t] = data;
   endtask

   task automatic do_read(input logic [31:0] addr, output int lat, output logic err);
      logic [26:0] t;
      bit          done;
      int          rc0;
      t           = addr[31:5];
      rc0         = rd_cnt;
      mem_read    = 1'b1;
      mem_address = addr;
      lat  = 0;
      done = 1'b0;
      err  = 1'b0;
      while (!done && lat < 300) begin
         @(posedge clk); #1;
         lat++;
         if (mem_resp) done = 1'b1;
      end
      mem_read = 1'b0;
      check_eq("read_done", done, 1'b1);
      if (!done) return;
      err = mem_error;
      check_eq("read_data", mem_rdata, shadow_val(t));
      check_eq("read_error", mem_error, (rd_cnt != rc0) ? last_rd_err : 1'b0);
   endtask

   task automatic wait_drained();
      int  n;
      bit  idle;
      n    = 0;
      idle = 1'b0;
      while (!idle && n < 1000) begin
         @(posedge clk); #1;
         n++;
         idle = (buf_q.size() == 0) && !pmem_write && !pmem_read;
      end
      check_eq("drain_finished", idle, 1'b1);
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin : main
      int           lat, d0, r0;
      logic         err;
      logic [31:0]  addr;
      logic [255:0] da, db;
      rst         = 1'b1;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = '0;
      mem_wdata   = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_mem_resp", mem_resp, 1'b0);
      check_eq("rst_mem_rdata", mem_rdata, '0);
      check_eq("rst_mem_error", mem_error, 1'b0);
      check_eq("rst_pmem_read", pmem_read, 1'b0);
      check_eq("rst_pmem_write", pmem_write, 1'b0);
      check_eq("rst_pmem_address", pmem_address, '0);
      check_eq("rst_pmem_wdata", pmem_wdata, '0);
      rst = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      check_eq("idle_no_pmem", pmem_read | pmem_write, 1'b0);

      // Single write, then autonomous drain.
      d0 = drain_cnt;
      da = rand_line();
      do_write(32'h100, da, lat);
      check_eq("write_lat", lat, 1);
      wait_drained();
      check_eq("single_drain_cnt", drain_cnt - d0, 1);
      check_eq("single_drain_mem", phys_val(27'h8), da);

      // Fill the buffer with memory held off, then a fifth write must stall.
      hold_resp = 1'b1;
      d0 = drain_cnt;
      for (int i = 0; i < 4; i++) begin
         do_write(32'(i * 32'h20), rand_line(), lat);
         // back-to-back requests pass through the one-cycle response state
         check_eq("fill_write_lat", lat, (i == 0) ? 1 : 2);
      end
      fork
         do_write(32'h80, rand_line(), lat);
         begin
            repeat (20) @(posedge clk);
            hold_resp = 1'b0;
         end
      join
      check_eq("full_write_stalled", lat > 20, 1'b1);
      wait_drained();
      check_eq("full_drain_cnt", drain_cnt - d0, 5);

      // Coalescing.
      d0 = drain_cnt;
      da = rand_line();
      db = rand_line();
      do_write(32'h200, da, lat);
      do_write(32'h200, db, lat);
      wait_drained();
      check_eq("coalesce_drain_cnt", drain_cnt - d0, 1);
      check_eq("coalesce_mem", phys_val(27'h10), db);

      // Read after write of the same line.
      d0 = drain_cnt;
      r0 = rd_cnt;
      do_write(32'h300, rand_line(), lat);
      do_read(32'h300, lat, err);
`ifdef PMEM_WB_FORWARD_EN
      check_eq("fwd_read_lat", lat, 2);
      check_eq("fwd_no_pmem_read", rd_cnt - r0, 0);
`else
      check_eq("nofwd_drain_first", drain_cnt - d0, 1);
      check_eq("nofwd_pmem_read", rd_cnt - r0, 1);
`endif
      wait_drained();

      // Read miss jumps ahead of pending drains and carries the error back.
      do_write(32'h500, rand_line(), lat);
      do_write(32'h520, rand_line(), lat);
      d0 = drain_cnt;
      r0 = rd_cnt;
      force_err = 1'b1;
      do_read(32'h400, lat, err);
      force_err = 1'b0;
      check_eq("miss_before_drain", drain_cnt - d0, 0);
      check_eq("miss_pmem_read", rd_cnt - r0, 1);
      check_eq("miss_error", err, 1'b1);
      wait_drained();

      // Reset in the middle of a drain with three lines buffered.
      hold_resp = 1'b1;
      do_write(32'h600, rand_line(), lat);
      do_write(32'h620, rand_line(), lat);
      do_write(32'h640, rand_line(), lat);
      repeat (3) begin
         @(posedge clk); #1;
      end
      check_eq("drain_active", pmem_write, 1'b1);
      check_eq("drain_active_addr", pmem_address, 32'h600);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check_eq("rst_drain_stop", pmem_write, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      foreach (buf_q[i]) shadow[buf_q[i].tag] = phys_val(buf_q[i].tag);
      buf_q.delete();
      hold_resp = 1'b0;
      d0 = drain_cnt;
      repeat (30) begin
         @(posedge clk); #1;
      end
      check_eq("rst_no_drain", drain_cnt - d0, 0);
      check_eq("rst_idle", pmem_write | pmem_read, 1'b0);
      do_write(32'h660, rand_line(), lat);
      wait_drained();
      check_eq("rst_count_cleared", drain_cnt - d0, 1);
      do_read(32'h600, lat, err);

      // Random traffic over a small line pool so hits and coalescing are frequent.
      for (int n = 0; n < 400; n++) begin
         addr = 32'h1000 + 32'($urandom_range(0, 5)) * 32'h20 + 32'($urandom_range(0, 31));
         if ($urandom_range(0, 9) < 6) do_write(addr, rand_line(), lat);
         else                          do_read(addr, lat, err);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
      end
      wait_drained();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
